card_scan_ctrl: RTL and testbench
=================================

Name: card_scan_ctrl

Overview:
- Sequencer that walks the two-level card table for the garbage collector.
- Takes a snapshot of the 32-bit master card table and visits only the regions whose master bit is set.
- Reads each 32-bit card word through a dedicated card-RAM port (port A timing) and streams each dirty card index out over a valid/ready handshake.
- Optionally clears the words and master bits it has consumed. Sits beside card_table, between the GC engine and the card RAM.

Parameters:
- RD_LATENCY, 2, card-RAM read latency in cycles from mem_en_o to valid mem_dat_i; legal range 1..4.
- CLEAR_ON_SCAN, 1'b1, 1 = zero each scanned word and pulse master clear; 0 = read-only scan.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  begin scan; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until DONE completes
- done_o  out  1  one-cycle pulse at end of scan
- master_i  in  32  live master card table; snapshotted on start
- master_clr_o  out  1  pulse: clear master bit master_clr_idx_o
- master_clr_idx_o  out  5  master bit index
- mem_en_o  out  1  card-RAM enable
- mem_we_o  out  1  card-RAM write
- mem_adr_o  out  10  card-RAM word address {m[4:0],w[4:0]}
- mem_dat_o  out  32  write data; always 0
- mem_dat_i  in  32  read data
- card_vld_o  out  1  dirty card index valid
- card_rdy_i  in  1  consumer ready
- card_idx_o  out  15  card index {m,w,b}

Behaviour:
- Synchronous, active-high reset. All outputs reset to 0; state returns to IDLE.
  - Reset mid-scan abandons the scan: no done_o pulse, no further writes.
- Geometry: 32 master bits × 32 words × 32 bits = 32768 cards. Master bit m covers words m*32..m*32+31.
- IDLE:
  - start_i=1 captures master_i into mreg; next state is MSCAN.
  - start_i while busy is ignored.
- MSCAN:
  - mreg==0 → DONE.
  - Otherwise m = lowest set bit of mreg; clear that bit in mreg; w=0; → RDREQ.
- RDREQ: mem_en_o=1, mem_we_o=0, mem_adr_o={m,w} for exactly one cycle → RDWAIT.
- RDWAIT: hold RD_LATENCY cycles. On the last cycle, capture mem_dat_i into wreg → BITSCAN.
- BITSCAN:
  - wreg==0 → CLRWR if CLEAR_ON_SCAN, else NEXTW.
  - Otherwise card_vld_o=1 and card_idx_o={m,w,b}, where b = lowest set bit of wreg.
  - On card_vld_o & card_rdy_i, clear bit b. With ready held high, one card is emitted per cycle.
  - card_vld_o and card_idx_o must stay stable while card_rdy_i=0.
- CLRWR: mem_en_o=1, mem_we_o=1, mem_adr_o={m,w}, mem_dat_o=0 for one cycle → NEXTW.
- NEXTW:
  - w==31 → MCLR.
  - Otherwise w+1 → RDREQ.
  - w is 5 bits and never wraps into m.
- MCLR: if CLEAR_ON_SCAN, pulse master_clr_o for one cycle with master_clr_idx_o=m. → MSCAN.
- DONE: done_o=1 for one cycle, busy_o drops the same cycle → IDLE.
- Latency: with the lowest dirty card in word 0 of the lowest set master bit, the first card_vld_o asserts RD_LATENCY+3 cycles after the start edge.
- A master_i bit that sets during a scan is not rescanned; the next start picks it up.
- Barrier writes landing between RDREQ and CLRWR of the same word are lost. The GC system stalls the mutator (or the barrier path) while busy_o=1; this block performs no interlock.

Optional Feature:
- Macro CARD_SCAN_STATS_EN.
- Defined: adds output dirty_cnt_o[15:0].
  - Cleared on start acceptance; +1 on each card handshake; saturates at 16'hFFFF.
  - Holds its value after DONE until the next start; reset value 0.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- card_pkg holds:
  - CARD_MASTER_BITS=32, CARD_WORDS_PER_MASTER=32, CARD_BITS_PER_WORD=32
  - typedef card_idx_t (logic [14:0]), card_wadr_t (logic [9:0])
  - enum scan_state_t {IDLE, MSCAN, RDREQ, RDWAIT, BITSCAN, CLRWR, NEXTW, MCLR, DONE}
- One sub-module: ffo32, a combinational 32-bit find-first-one returning a 5-bit index plus found flag. It is instanced twice, for mreg and wreg.

Test Plan:
- master_i=0, start → no mem_en_o; done_o pulses 2 cycles after start; busy_o high for 1 cycle.
- master_i=32'h8, word 96 = 32'h1, others 0, rdy=1:
  - first card_vld_o at cycle 5 (RD_LATENCY=2), card_idx_o=15'h0C00.
  - 32 reads and 32 clear writes to words 96..127; master_clr_o with idx 3.
- Word 0 = 32'h8000_0005, master bit 0, rdy=1 → indices 0, 2, 31 on consecutive cycles.
  - Repeat with rdy toggling 1010… → same three indices, each held stable while rdy=0.
- CLEAR_ON_SCAN=0, master bits 0 and 31 set → no mem_we_o or master_clr_o; the second scan emits the same index list as the first.
- rst_i asserted during BITSCAN with card_vld_o=1 → next cycle all outputs 0 and state IDLE; no done_o pulse.
- CARD_SCAN_STATS_EN defined, 70 dirty cards across 3 words → dirty_cnt_o=70 after done_o; a new start resets it to 0.

Source files
------------

// File: rtl/card_pkg.sv
// Card-table geometry, index/address types and scan FSM encoding shared by the scan path.
package card_pkg;

    localparam int CARD_MASTER_BITS      = 32;
    localparam int CARD_WORDS_PER_MASTER = 32;
    localparam int CARD_BITS_PER_WORD    = 32;

    typedef logic [14:0] card_idx_t;
    typedef logic [9:0]  card_wadr_t;

    typedef enum logic [3:0] {
        IDLE,
        MSCAN,
        RDREQ,
        RDWAIT,
        BITSCAN,
        CLRWR,
        NEXTW,
        MCLR,
        DONE
    } scan_state_t;

    function automatic card_wadr_t card_word_adr(input logic [4:0] m, input logic [4:0] w);
        return {m, w};
    endfunction

endpackage

// File: rtl/ffo32.sv
// Combinational find-first-one: index of the lowest set bit of a 32-bit vector, plus a found flag.
module ffo32 (
    input  logic [31:0] vec_i,
    output logic [4:0]  idx_o,
    output logic        found_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 5'(i);
        end
    end

    assign found_o = |vec_i;

endmodule

// File: rtl/card_scan_ctrl.sv
// Two-level card-table scanner: first dirty card index RD_LATENCY+3 cycles after start, one card/cycle under ready.
// Holds card_vld_o/card_idx_o while card_rdy_i is low; CARD_SCAN_STATS_EN adds the dirty_cnt_o counter.
module card_scan_ctrl
    import card_pkg::*;
#(
    parameter int unsigned RD_LATENCY    = 2,
    parameter bit          CLEAR_ON_SCAN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [31:0] master_i,
    output logic        master_clr_o,
    output logic [4:0]  master_clr_idx_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [9:0]  mem_adr_o,
    output logic [31:0] mem_dat_o,
    input  logic [31:0] mem_dat_i,
    output logic        card_vld_o,
    input  logic        card_rdy_i,
    output logic [14:0] card_idx_o
`ifdef CARD_SCAN_STATS_EN
    ,
    output logic [15:0] dirty_cnt_o
`endif
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    scan_state_t state_q;
    logic [31:0] mreg_q;
    logic [31:0] wreg_q;
    logic [4:0]  m_q;
    logic [4:0]  w_q;
    logic [1:0]  lat_q;
    logic        busy_q;
    logic        done_q;
    logic        mclr_q;
    logic [4:0]  mclr_idx_q;
    logic        mem_en_q;
    logic        mem_we_q;
    card_wadr_t  mem_adr_q;

    logic [4:0]  m_idx;
    logic        m_found;
    logic [4:0]  w_idx;
    logic        w_found;

    ffo32 u_ffo_master (
        .vec_i   (mreg_q),
        .idx_o   (m_idx),
        .found_o (m_found)
    );

    ffo32 u_ffo_word (
        .vec_i   (wreg_q),
        .idx_o   (w_idx),
        .found_o (w_found)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mreg_q     <= '0;
            wreg_q     <= '0;
            m_q        <= '0;
            w_q        <= '0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mclr_q     <= 1'b0;
            mclr_idx_q <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            mclr_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mreg_q  <= master_i;
                        busy_q  <= 1'b1;
                        state_q <= MSCAN;
                    end
                end
                MSCAN: begin
                    if (!m_found) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        m_q           <= m_idx;
                        w_q           <= '0;
                        mreg_q[m_idx] <= 1'b0;
                        mem_en_q      <= 1'b1;
                        mem_adr_q     <= card_word_adr(m_idx, 5'd0);
                        state_q       <= RDREQ;
                    end
                end
                RDREQ: begin
                    lat_q   <= LAT_LAST;
                    state_q <= RDWAIT;
                end
                RDWAIT: begin
                    if (lat_q == 2'd0) begin
                        wreg_q  <= mem_dat_i;
                        state_q <= BITSCAN;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                BITSCAN: begin
                    if (!w_found) begin
                        if (CLEAR_ON_SCAN) begin
                            mem_en_q  <= 1'b1;
                            mem_we_q  <= 1'b1;
                            mem_adr_q <= card_word_adr(m_q, w_q);
                            state_q   <= CLRWR;
                        end else begin
                            state_q <= NEXTW;
                        end
                    end else if (card_rdy_i) begin
                        wreg_q[w_idx] <= 1'b0;
                    end
                end
                CLRWR: state_q <= NEXTW;
                NEXTW: begin
                    // w is a separate 5-bit field, so the last word ends the region instead of wrapping into m.
                    if (w_q == 5'd31) begin
                        if (CLEAR_ON_SCAN) begin
                            mclr_q     <= 1'b1;
                            mclr_idx_q <= m_q;
                        end
                        state_q <= MCLR;
                    end else begin
                        w_q       <= w_q + 5'd1;
                        mem_en_q  <= 1'b1;
                        mem_adr_q <= card_word_adr(m_q, w_q + 5'd1);
                        state_q   <= RDREQ;
                    end
                end
                MCLR:    state_q <= MSCAN;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign master_clr_o     = mclr_q;
    assign master_clr_idx_o = mclr_idx_q;
    assign mem_en_o         = mem_en_q;
    assign mem_we_o         = mem_we_q;
    assign mem_adr_o        = mem_adr_q;
    assign mem_dat_o        = '0;

    // wreg only changes on a handshake, which keeps valid/index stable under backpressure.
    assign card_vld_o = (state_q == BITSCAN) && w_found;
    assign card_idx_o = card_vld_o ? {m_q, w_q, w_idx} : '0;

`ifdef CARD_SCAN_STATS_EN
    logic        card_hs;
    logic [15:0] dirty_cnt_q;
    logic [15:0] dirty_cnt_d;

    assign card_hs = card_vld_o & card_rdy_i;

    always_comb begin
        dirty_cnt_d = dirty_cnt_q;
        if ((state_q == IDLE) && start_i) begin
            dirty_cnt_d = '0;
        end else if (card_hs && (dirty_cnt_q != 16'hFFFF)) begin
            dirty_cnt_d = dirty_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty_cnt_q <= '0;
        end else begin
            dirty_cnt_q <= dirty_cnt_d;
        end
    end

    assign dirty_cnt_o = dirty_cnt_q;
`endif

endmodule

// File: tb/tb_card_scan_ctrl.sv
// Directed bench: clearing scanner (A) and read-only scanner (B), each with a latency-accurate card-RAM model.
module tb_card_scan_ctrl;

    localparam int RDL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_mclr, a_en, a_we, a_vld, a_rdy;
    logic [31:0] a_master, a_wdat, a_rdat;
    logic [4:0]  a_mclr_idx;
    logic [9:0]  a_adr;
    logic [14:0] a_idx;
    logic        b_start, b_busy, b_done, b_mclr, b_en, b_we, b_vld, b_rdy;
    logic [31:0] b_master, b_wdat, b_rdat;
    logic [4:0]  b_mclr_idx;
    logic [9:0]  b_adr;
    logic [14:0] b_idx;
`ifdef CARD_SCAN_STATS_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    card_scan_ctrl #(.RD_LATENCY(RDL), .CLEAR_ON_SCAN(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .master_i(a_master), .master_clr_o(a_mclr), .master_clr_idx_o(a_mclr_idx),
        .mem_en_o(a_en), .mem_we_o(a_we), .mem_adr_o(a_adr), .mem_dat_o(a_wdat), .mem_dat_i(a_rdat),
        .card_vld_o(a_vld), .card_rdy_i(a_rdy), .card_idx_o(a_idx)
`ifdef CARD_SCAN_STATS_EN
        , .dirty_cnt_o(a_cnt)
`endif
    );

    card_scan_ctrl #(.RD_LATENCY(RDL), .CLEAR_ON_SCAN(1'b0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .master_i(b_master), .master_clr_o(b_mclr), .master_clr_idx_o(b_mclr_idx),
        .mem_en_o(b_en), .mem_we_o(b_we), .mem_adr_o(b_adr), .mem_dat_o(b_wdat), .mem_dat_i(b_rdat),
        .card_vld_o(b_vld), .card_rdy_i(b_rdy), .card_idx_o(b_idx)
`ifdef CARD_SCAN_STATS_EN
        , .dirty_cnt_o(b_cnt)
`endif
    );

    // Card-RAM models: read data appears RDL cycles after the enable cycle, zero otherwise.
    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];
    logic [31:0] pipe_a [4];
    logic [31:0] pipe_b [4];
    logic        ld_vld, ld_sel, ld_clr;
    logic [9:0]  ld_adr;
    logic [31:0] ld_dat;

    always @(posedge clk) begin
        if (ld_clr && !ld_sel) for (int i = 0; i < 1024; i++) ram_a[i] <= '0;
        else if (ld_vld && !ld_sel) ram_a[ld_adr] <= ld_dat;
        else if (a_en && a_we) ram_a[a_adr] <= a_wdat;
        pipe_a[0] <= (a_en && !a_we) ? ram_a[a_adr] : 32'h0;
        for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign a_rdat = pipe_a[RDL-1];

    always @(posedge clk) begin
        if (ld_clr && ld_sel) for (int i = 0; i < 1024; i++) ram_b[i] <= '0;
        else if (ld_vld && ld_sel) ram_b[ld_adr] <= ld_dat;
        else if (b_en && b_we) ram_b[b_adr] <= b_wdat;
        pipe_b[0] <= (b_en && !b_we) ? ram_b[b_adr] : 32'h0;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign b_rdat = pipe_b[RDL-1];

    logic rdy_toggle = 1'b0;
    logic rdy_level  = 1'b1;
    always @(posedge clk) begin
        #1;
        a_rdy = rdy_toggle ? ~a_rdy : rdy_level;
    end
    assign b_rdy = 1'b1;

    // Event logs, sampled on the falling edge.
    logic [9:0]  rd_q[$], wr_q[$];
    logic [4:0]  mclr_q[$];
    logic [14:0] card_q[$], b_card_q[$];
    int          card_cyc_q[$];
    int cyc = 0, done_n = 0, hold_n = 0, hold_bad = 0, wdat_bad = 0;
    int b_rd_n = 0, b_we_n = 0, b_mclr_n = 0;
    logic        p_vld = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
    logic [14:0] p_idx = '0;

    always @(negedge clk) begin
        cyc++;
        if (a_en && !a_we) rd_q.push_back(a_adr);
        if (a_en && a_we) begin
            wr_q.push_back(a_adr);
            if (a_wdat != 32'h0) wdat_bad++;
        end
        if (a_mclr) mclr_q.push_back(a_mclr_idx);
        if (a_done) done_n++;
        if (a_vld && a_rdy) begin
            card_q.push_back(a_idx);
            card_cyc_q.push_back(cyc);
        end
        if (p_vld && !p_rdy && !p_rst) begin
            hold_n++;
            if (!a_vld || (a_idx != p_idx)) hold_bad++;
        end
        p_vld = a_vld; p_rdy = a_rdy; p_idx = a_idx; p_rst = rst;
        if (b_en && !b_we) b_rd_n++;
        if (b_en && b_we) b_we_n++;
        if (b_mclr) b_mclr_n++;
        if (b_vld && b_rdy) b_card_q.push_back(b_idx);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ram_clr(input logic sel);
        ld_sel = sel; ld_clr = 1'b1; tick(); ld_clr = 1'b0;
    endtask

    task automatic ram_wr(input logic sel, input logic [9:0] adr, input logic [31:0] dat);
        ld_sel = sel; ld_adr = adr; ld_dat = dat; ld_vld = 1'b1; tick(); ld_vld = 1'b0;
    endtask

    task automatic run_a(input logic [31:0] m, input string nm);
        int n;
        a_master = m; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_done && n < 4000) begin tick(); n++; end
        check({nm, "_done"}, 64'(a_done), 64'd1);
        tick();
    endtask

    task automatic run_b(input logic [31:0] m, input string nm);
        int n;
        b_master = m; b_start = 1'b1; tick(); b_start = 1'b0;
        n = 0;
        while (!b_done && n < 4000) begin tick(); n++; end
        check({nm, "_done"}, 64'(b_done), 64'd1);
        tick();
    endtask

    typedef struct {
        logic [31:0] master;
        logic [9:0]  wadr;
        logic [31:0] wdat;
        int          n_cards;
        logic [14:0] first;
        int          n_rd;
        int          n_wr;
        int          n_mclr;
        logic [4:0]  last_mclr;
    } vec_t;

    vec_t tv [6];
    logic [14:0] exp_l[$];
    logic [14:0] exp_b [3];
    logic [14:0] exp_t [3];
    int cb, rb, wb, mb, db, hb, hbad, b0, b1, bwe, bmc, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{32'h0000_0000, 10'd0,    32'h0000_00FF, 0,  15'h0000, 0,  0,  0, 5'd0};
        tv[1] = '{32'h0000_0008, 10'd96,   32'h0000_0001, 1,  15'h0C00, 32, 32, 1, 5'd3};
        tv[2] = '{32'h0000_0001, 10'd0,    32'h8000_0005, 3,  15'h0000, 32, 32, 1, 5'd0};
        tv[3] = '{32'h8000_0001, 10'd1023, 32'h0001_0000, 1,  15'h7FF0, 64, 64, 2, 5'd31};
        tv[4] = '{32'h0000_0010, 10'd160,  32'hFFFF_FFFF, 0,  15'h0000, 32, 32, 1, 5'd4};
        tv[5] = '{32'h0000_0020, 10'd167,  32'hFFFF_FFFF, 32, 15'h14E0, 32, 32, 1, 5'd5};
        exp_b = '{15'h0001, 15'h0002, 15'h7FFF};
        exp_t = '{15'h0000, 15'h0002, 15'h001F};

        a_start = 0; a_master = 0; b_start = 0; b_master = 0;
        ld_vld = 0; ld_sel = 0; ld_clr = 0; ld_adr = 0; ld_dat = 0;
        rst = 1'b1;
        tick(3);
        check("reset_a_outs", {a_busy, a_done, a_mclr, a_mclr_idx, a_en, a_we, a_adr, a_vld, a_idx}, 64'd0);
        check("reset_a_wdat", a_wdat, 64'd0);
        check("reset_b_outs", {b_busy, b_done, b_mclr, b_mclr_idx, b_en, b_we, b_adr, b_vld, b_idx}, 64'd0);
        rst = 1'b0;
        tick();

        // Empty master table: done two cycles after the start cycle, busy for one cycle.
        rb = rd_q.size();
        a_master = 32'h0; a_start = 1'b1; tick(); a_start = 1'b0;
        check("empty_busy_c1", {a_busy, a_done}, 64'b10);
        tick();
        check("empty_done_c2", {a_busy, a_done}, 64'b01);
        tick();
        check("empty_done_gone", {a_busy, a_done}, 64'b00);
        check("empty_no_reads", rd_q.size() - rb, 64'd0);

        // First-card latency, a repeated start while busy, and the exact address range.
        ram_clr(0); ram_wr(0, 10'd96, 32'h1);
        rb = rd_q.size(); wb = wr_q.size(); mb = mclr_q.size(); db = done_n;
        a_master = 32'h8; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_vld && n < 50) begin
            tick(); n++;
            if (n == 1) check("lat_rdreq", {a_en, a_we, a_adr}, {2'b10, 10'd96});
        end
        check("lat_first_vld", n, RDL + 2);
        check("lat_first_idx", a_idx, 15'h0C00);
        a_master = 32'hFFFF_FFFF; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_done && n < 4000) begin tick(); n++; end
        tick(2);
        check("lat_reads", rd_q.size() - rb, 64'd32);
        check("lat_writes", wr_q.size() - wb, 64'd32);
        check("lat_rd_lo", rd_q[rb], 64'd96);
        check("lat_rd_hi", rd_q[rd_q.size()-1], 64'd127);
        check("lat_wr_lo", wr_q[wb], 64'd96);
        check("lat_wr_hi", wr_q[wr_q.size()-1], 64'd127);
        check("lat_mclr_n", mclr_q.size() - mb, 64'd1);
        check("lat_mclr_idx", mclr_q[mclr_q.size()-1], 64'd3);
        check("lat_one_done", done_n - db, 64'd1);

        // Table of single-word scans with ready held high.
        for (int k = 0; k < 6; k++) begin
            ram_clr(0);
            ram_wr(0, tv[k].wadr, tv[k].wdat);
            rb = rd_q.size(); wb = wr_q.size(); mb = mclr_q.size(); cb = card_q.size();
            run_a(tv[k].master, $sformatf("v%0d", k));
            check($sformatf("v%0d_cards", k), card_q.size() - cb, tv[k].n_cards);
            if (tv[k].n_cards > 0 && card_q.size() > cb)
                check($sformatf("v%0d_first", k), card_q[cb], tv[k].first);
            check($sformatf("v%0d_reads", k), rd_q.size() - rb, tv[k].n_rd);
            check($sformatf("v%0d_writes", k), wr_q.size() - wb, tv[k].n_wr);
            check($sformatf("v%0d_mclr_n", k), mclr_q.size() - mb, tv[k].n_mclr);
            if (tv[k].n_mclr > 0)
                check($sformatf("v%0d_mclr_idx", k), mclr_q[mclr_q.size()-1], tv[k].last_mclr);
            exp_l.delete();
            if (tv[k].master[tv[k].wadr[9:5]]) begin
                for (int b = 0; b < 32; b++)
                    if (tv[k].wdat[b]) exp_l.push_back({tv[k].wadr, 5'(b)});
                check($sformatf("v%0d_word_cleared", k), ram_a[tv[k].wadr], 64'd0);
            end
            for (int e = 0; e < exp_l.size(); e++) begin
                if (cb + e < card_q.size()) begin
                    check($sformatf("v%0d_card%0d", k, e), card_q[cb+e], exp_l[e]);
                    if (e > 0)
                        check($sformatf("v%0d_gap%0d", k, e), card_cyc_q[cb+e] - card_cyc_q[cb+e-1], 64'd1);
                end
            end
        end
        check("clear_data_zero", wdat_bad, 64'd0);

        // Ready toggling 1010: same cards, each held while ready is low.
        ram_clr(0); ram_wr(0, 10'd0, 32'h8000_0005);
        cb = card_q.size(); hb = hold_n; hbad = hold_bad;
        rdy_toggle = 1'b1;
        run_a(32'h1, "tog");
        rdy_toggle = 1'b0; rdy_level = 1'b1;
        tick(2);
        check("tog_cards", card_q.size() - cb, 64'd3);
        for (int e = 0; e < 3; e++)
            if (cb + e < card_q.size()) check($sformatf("tog_card%0d", e), card_q[cb+e], exp_t[e]);
        check("tog_hold_seen", 64'(hold_n - hb > 0), 64'd1);
        check("tog_hold_stable", hold_bad - hbad, 64'd0);

        // Read-only scanner: nothing written or cleared, second scan repeats the first.
        ram_clr(1); ram_wr(1, 10'd0, 32'h6); ram_wr(1, 10'd1023, 32'h8000_0000);
        bwe = b_we_n; bmc = b_mclr_n; rb = b_rd_n;
        b0 = b_card_q.size();
        run_b(32'h8000_0001, "ro1");
        b1 = b_card_q.size();
        run_b(32'h8000_0001, "ro2");
        check("ro_reads", b_rd_n - rb, 64'd128);
        check("ro_no_writes", b_we_n - bwe, 64'd0);
        check("ro_no_mclr", b_mclr_n - bmc, 64'd0);
        check("ro_cards1", b1 - b0, 64'd3);
        check("ro_cards2", b_card_q.size() - b1, 64'd3);
        for (int e = 0; e < 3; e++) begin
            if (b1 + 3 <= b_card_q.size() && b0 + 3 <= b1) begin
                check($sformatf("ro1_card%0d", e), b_card_q[b0+e], exp_b[e]);
                check($sformatf("ro2_card%0d", e), b_card_q[b1+e], exp_b[e]);
            end
        end
        check("ro_word_kept", ram_b[0], 64'h6);

        // Reset while a card is being offered: everything drops, no done, no further writes.
        ram_clr(0); ram_wr(0, 10'd0, 32'h8000_0005);
        rdy_level = 1'b0; tick();
        a_master = 32'h1; a_start = 1'b1; tick(); a_start = 1'b0;
        n = 0;
        while (!a_vld && n < 50) begin tick(); n++; end
        check("rst_pre_vld", a_vld, 64'd1);
        db = done_n; wb = wr_q.size();
        rst = 1'b1; tick();
        check("rst_mid_outs", {a_busy, a_done, a_mclr, a_mclr_idx, a_en, a_we, a_adr, a_vld, a_idx}, 64'd0);
        check("rst_mid_wdat", a_wdat, 64'd0);
        rst = 1'b0; rdy_level = 1'b1;
        tick(40);
        check("rst_no_done", done_n - db, 64'd0);
        check("rst_no_writes", wr_q.size() - wb, 64'd0);
        check("rst_idle", {a_busy, a_vld, a_en}, 64'd0);

`ifdef CARD_SCAN_STATS_EN
        ram_clr(0);
        ram_wr(0, 10'd64, 32'hFFFF_FFFF);
        ram_wr(0, 10'd65, 32'hFFFF_FFFF);
        ram_wr(0, 10'd70, 32'h0000_003F);
        run_a(32'h4, "stats");
        tick(3);
        check("stats_count", a_cnt, 64'd70);
        a_master = 32'h0; a_start = 1'b1; tick(); a_start = 1'b0;
        check("stats_restart", a_cnt, 64'd0);
        tick(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
